// File: rtl/pipe_pkg.sv
// Shared widths and slot/result layouts for the series pipeline and its loop controller.
package pipe_pkg;
    localparam int          W     = 32;
    localparam int          IW    = 3;
    localparam logic [2:0]  N     = 3'b111;
    localparam int          DEPTH = 8;
    localparam int          CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [W-1:0]  x;
        logic [W-1:0]  num;
        logic [W-1:0]  sum;
        logic [IW-1:0] i;
        logic          overflow;
        logic          flag_next;
    } slot_t;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] sum;
        logic         overflow;
    } res_t;
endpackage

// File: rtl/pipe_loop_ctrl_if.sv
// Operand stream, pipeline slot buses and result stream of the loop controller.
interface pipe_loop_ctrl_if import pipe_pkg::*; ();
    logic [W-1:0]  s_x;
    logic          s_valid;
    logic          s_ready;

    logic [W-1:0]  pipe_x;
    logic [W-1:0]  pipe_num;
    logic [W-1:0]  pipe_sum;
    logic [IW-1:0] pipe_i;
    logic          pipe_overflow;
    logic          pipe_valid;
    logic          pipe_flag_next;

    logic [W-1:0]  ret_x;
    logic [W-1:0]  ret_num;
    logic [W-1:0]  ret_sum;
    logic [IW-1:0] ret_i;
    logic          ret_overflow;
    logic          ret_valid;
    logic          ret_flag_next;

    logic [W-1:0]  m_x;
    logic [W-1:0]  m_sum;
    logic          m_overflow;
    logic          m_valid;
    logic          m_ready;

    logic          busy;

    modport master (
        input  s_x, s_valid,
        output s_ready,
        output pipe_x, pipe_num, pipe_sum, pipe_i, pipe_overflow, pipe_valid, pipe_flag_next,
        input  ret_x, ret_num, ret_sum, ret_i, ret_overflow, ret_valid, ret_flag_next,
        output m_x, m_sum, m_overflow, m_valid,
        input  m_ready,
        output busy
    );

    modport slave (
        output s_x, s_valid,
        input  s_ready,
        input  pipe_x, pipe_num, pipe_sum, pipe_i, pipe_overflow, pipe_valid, pipe_flag_next,
        output ret_x, ret_num, ret_sum, ret_i, ret_overflow, ret_valid, ret_flag_next,
        input  m_x, m_sum, m_overflow, m_valid,
        output m_ready,
        input  busy
    );
endinterface

// File: rtl/pipe_loop_ctrl_result_fifo.sv
// First-word-fall-through result buffer; head visible the cycle after the push.
// No backpressure on push: the caller's credit scheme guarantees space.
module result_fifo import pipe_pkg::*; #(
    parameter int DEPTH_P = DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  res_t i_push_dat,
    input  logic i_pop,
    output res_t o_head,
    output logic o_full,
    output logic o_empty
);
    localparam int AW = $clog2(DEPTH_P);

    res_t         r_mem [DEPTH_P];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_push_ok;
    logic         w_pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_head    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            if (w_pop_ok)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr[AW-1:0]] <= i_push_dat;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(i_push && o_full && !w_pop_ok));
    end
endmodule

// File: rtl/pipe_loop_ctrl.sv
// Issues new/recirculated items into the 4-cycle series loop and buffers finished sums.
// Recirculation owns the slot; admission is credit-limited to the result FIFO depth.
module pipe_loop_ctrl import pipe_pkg::*; (
    input  logic clk,
    input  logic rst,
    pipe_loop_ctrl_if.master bus
);
    slot_t          r_slot;
    logic           r_vld;
    logic [CW-1:0]  r_credits;

    logic           w_done;
    logic           w_recirc;
    logic           w_admit;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    res_t           w_push_dat;
    res_t           w_head;

    assign w_done   = bus.ret_valid && ((bus.ret_i == N) || bus.ret_overflow);
    assign w_recirc = bus.ret_valid && !w_done;

    assign bus.s_ready = !rst && !w_recirc && (r_credits < CW'(DEPTH));
    assign w_admit     = bus.s_valid && bus.s_ready;
    assign w_pop       = bus.m_valid && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
            r_vld  <= 1'b0;
        end else if (w_recirc) begin
            r_slot <= '{x: bus.ret_x, num: bus.ret_num, sum: bus.ret_sum, i: bus.ret_i,
                        overflow: bus.ret_overflow, flag_next: 1'b1};
            r_vld  <= 1'b1;
        end else if (w_admit) begin
            r_slot <= '{x: bus.s_x, num: bus.s_x, sum: '0, i: '0,
                        overflow: 1'b0, flag_next: 1'b0};
            r_vld  <= 1'b1;
        end else begin
            r_vld  <= 1'b0;
        end
    end

    // A credit is held from admission until the result leaves the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= '0;
        end else begin
            case ({w_admit, w_pop})
                2'b10:   r_credits <= r_credits + CW'(1);
                2'b01:   r_credits <= r_credits - CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign bus.pipe_x         = r_slot.x;
    assign bus.pipe_num       = r_slot.num;
    assign bus.pipe_sum       = r_slot.sum;
    assign bus.pipe_i         = r_slot.i;
    assign bus.pipe_overflow  = r_slot.overflow;
    assign bus.pipe_flag_next = r_slot.flag_next;
    assign bus.pipe_valid     = r_vld;

    assign w_push_dat = '{x: bus.ret_x, sum: bus.ret_sum, overflow: bus.ret_overflow};

    result_fifo #(.DEPTH_P(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_done),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign bus.m_valid    = !w_empty;
    assign bus.m_x        = w_head.x;
    assign bus.m_sum      = w_head.sum;
    assign bus.m_overflow = w_head.overflow;
    assign bus.busy       = (r_credits != '0);
endmodule
